// File: rtl/instr_buffer.sv
// Two-wide instruction queue between fetch and decode: accepts two-instruction
// fetch packets and presents the two oldest entries to decode in program order.
module instr_buffer #(
   parameter int DEPTH = 8,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [129:0]     data_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic             must_flush,
   output logic             valid_0,
   output logic [31:0]      pc_0,
   output logic [31:0]      instr_0,
   output logic             taken_0,
   output logic             valid_1,
   output logic [31:0]      pc_1,
   output logic [31:0]      instr_1,
   output logic             taken_1,
   input  logic             deq_0,
   input  logic             deq_1,
   output logic [CNT_W-1:0] occupancy
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        taken;
   } entry_t;

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_p1, wr_ptr_p1;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push;
   logic [1:0]       pop_req, pop_n;
   entry_t           slot_a, slot_b, ent_0, ent_1;

   assign slot_a    = entry_t'(data_in[64:0]);
   assign slot_b    = entry_t'(data_in[129:65]);
   assign rd_ptr_p1 = rd_ptr_q + PTR_W'(1);
   assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

   // Depends only on registered count, keeping decode out of fetch's ready path.
   assign ready_out = (count_q <= CNT_W'(DEPTH - 2));
   assign push      = valid_in & ready_out & ~must_flush;

   always_comb begin
      pop_req = 2'd0;
      if (deq_0) pop_req = deq_1 ? 2'd2 : 2'd1;
      pop_n = pop_req;
      if (CNT_W'(pop_req) > count_q) pop_n = count_q[1:0];

      count_d  = count_q + (push ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(pop_n);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      wr_ptr_d = push ? (wr_ptr_q + PTR_W'(2)) : wr_ptr_q;

      if (must_flush) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage carries no reset; validity is tracked solely by count_q.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q]  <= slot_a;
         mem_q[wr_ptr_p1] <= slot_b;
      end
   end

   assign ent_0     = mem_q[rd_ptr_q];
   assign ent_1     = mem_q[rd_ptr_p1];

   assign valid_0   = (count_q >= CNT_W'(1));
   assign valid_1   = (count_q >= CNT_W'(2));
   assign pc_0      = ent_0.pc;
   assign instr_0   = ent_0.instr;
   assign taken_0   = ent_0.taken;
   assign pc_1      = ent_1.pc;
   assign instr_1   = ent_1.instr;
   assign taken_1   = ent_1.taken;
   assign occupancy = count_q;

endmodule

// File: tb/tb_instr_buffer.sv
// Directed bench for instr_buffer with a queue-based scoreboard of expected entries.
module tb_instr_buffer;

   localparam int DEPTH = 8;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        taken;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [129:0]     data_in;
   logic             valid_in;
   logic             ready_out;
   logic             must_flush;
   logic             valid_0, valid_1;
   logic [31:0]      pc_0, instr_0, pc_1, instr_1;
   logic             taken_0, taken_1;
   logic             deq_0, deq_1;
   logic [CNT_W-1:0] occupancy;

   ent_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   instr_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .must_flush(must_flush),
      .valid_0(valid_0), .pc_0(pc_0), .instr_0(instr_0), .taken_0(taken_0),
      .valid_1(valid_1), .pc_1(pc_1), .instr_1(instr_1), .taken_1(taken_1),
      .deq_0(deq_0), .deq_1(deq_1), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [129:0] mk(input logic [31:0] pc, input logic ta, input logic tb);
      ent_t a, b;
      a = '{pc: pc,       instr: pc ^ 32'hA5A5_0013,       taken: ta};
      b = '{pc: pc + 32'd4, instr: (pc + 32'd4) ^ 32'h5A5A_0093, taken: tb};
      return {b, a};
   endfunction

   task automatic chk_status(input string tag);
      chk({tag, "_occ"},    64'(occupancy), 64'(sb.size()));
      chk({tag, "_v0"},     64'(valid_0),   64'(sb.size() >= 1));
      chk({tag, "_v1"},     64'(valid_1),   64'(sb.size() >= 2));
      chk({tag, "_ready"},  64'(ready_out), 64'(sb.size() <= DEPTH - 2));
   endtask

   // Applies the currently driven inputs for one clock edge and updates the model.
   task automatic tick(input string tag);
      int pn;
      bit do_push;
      ent_t a, b;
      pn = 0;
      do_push = 1'b0;
      if (!must_flush) begin
         pn = deq_0 ? (deq_1 ? 2 : 1) : 0;
         if (pn > sb.size()) pn = sb.size();
         if (pn >= 1) begin
            chk({tag, "_pc0"},  64'(pc_0),    64'(sb[0].pc));
            chk({tag, "_in0"},  64'(instr_0), 64'(sb[0].instr));
            chk({tag, "_tk0"},  64'(taken_0), 64'(sb[0].taken));
         end
         if (pn == 2) begin
            chk({tag, "_pc1"},  64'(pc_1),    64'(sb[1].pc));
            chk({tag, "_in1"},  64'(instr_1), 64'(sb[1].instr));
            chk({tag, "_tk1"},  64'(taken_1), 64'(sb[1].taken));
         end
         do_push = valid_in && (sb.size() <= DEPTH - 2);
      end
      a = ent_t'(data_in[64:0]);
      b = ent_t'(data_in[129:65]);
      @(posedge clk);
      #1;
      if (must_flush) sb.delete();
      else begin
         for (int k = 0; k < pn; k++) void'(sb.pop_front());
         if (do_push) begin
            sb.push_back(a);
            sb.push_back(b);
         end
      end
      chk_status(tag);
   endtask

   task automatic drive(input logic v, input logic [129:0] d, input logic d0,
                        input logic d1, input logic fl);
      valid_in = v; data_in = d; deq_0 = d0; deq_1 = d1; must_flush = fl;
   endtask

   initial begin
      logic [31:0] prev_pc;
      ent_t ea, eb;
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #12;
      chk("rst_v0",    64'(valid_0),   64'd0);
      chk("rst_v1",    64'(valid_1),   64'd0);
      chk("rst_ready", 64'(ready_out), 64'd1);
      chk("rst_occ",   64'(occupancy), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // First packet: exact test-plan values.
      ea = '{pc: 32'h100, instr: 32'h0000_0013, taken: 1'b0};
      eb = '{pc: 32'h104, instr: 32'h0010_0093, taken: 1'b0};
      drive(1'b1, {eb, ea}, 1'b0, 1'b0, 1'b0);
      tick("first");
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("first_pc0", 64'(pc_0), 64'h100);
      chk("first_pc1", 64'(pc_1), 64'h104);
      chk("first_occ", 64'(occupancy), 64'd2);

      // Fill to full, then hold a packet that must not be accepted.
      for (int i = 1; i < 4; i++) begin
         drive(1'b1, mk(32'h100 + 32'(8 * i), i[0], 1'b1), 1'b0, 1'b0, 1'b0);
         tick("fill");
      end
      chk("full_occ",   64'(occupancy), 64'd8);
      chk("full_ready", 64'(ready_out), 64'd0);
      drive(1'b1, mk(32'h900, 1'b1, 1'b1), 1'b0, 1'b0, 1'b0);
      tick("hold");
      tick("hold");
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      tick("pop2full");
      chk("pop2_occ",   64'(occupancy), 64'd6);
      chk("pop2_ready", 64'(ready_out), 64'd1);
      chk("pop2_pc0",   64'(pc_0),      64'h108);

      // Count 7 boundary, single pop, then push with double pop.
      drive(1'b1, mk(32'h300, 1'b1, 1'b0), 1'b1, 1'b0, 1'b0);
      tick("to7");
      chk("c7_ready", 64'(ready_out), 64'd0);
      drive(1'b1, mk(32'h400, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
      tick("c7pop");
      chk("c6_occ", 64'(occupancy), 64'd6);
      drive(1'b1, mk(32'h500, 1'b0, 1'b1), 1'b1, 1'b1, 1'b0);
      tick("pushpop");
      chk("pp_occ", 64'(occupancy), 64'd6);

      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) tick("drain");
      chk("drained", 64'(occupancy), 64'd0);

      // Streaming across pointer wrap with two pops per cycle.
      prev_pc = '0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, mk(32'(8 * i), (i % 3) == 0, (i % 5) == 1), 1'b1, 1'b1, 1'b0);
         tick("stream");
         chk("stream_pc0", 64'(pc_0), 64'(8 * i));
         if (i > 0) chk("stream_step", 64'(pc_0 - prev_pc), 64'd8);
         prev_pc = pc_0;
      end
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      tick("stream_end");

      // Flush at count 5 together with push and pop.
      drive(1'b1, mk(32'h1000, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
      tick("f_a");
      drive(1'b1, mk(32'h1008, 1'b0, 1'b0), 1'b0, 1'b0, 1'b0);
      tick("f_b");
      drive(1'b1, mk(32'h1010, 1'b0, 1'b0), 1'b1, 1'b0, 1'b0);
      tick("f_c");
      chk("f_c5", 64'(occupancy), 64'd5);
      drive(1'b1, mk(32'h1018, 1'b1, 1'b1), 1'b1, 1'b0, 1'b1);
      tick("flush");
      chk("flush_occ",   64'(occupancy), 64'd0);
      chk("flush_v0",    64'(valid_0),   64'd0);
      chk("flush_ready", 64'(ready_out), 64'd1);
      drive(1'b1, mk(32'h2000, 1'b1, 1'b0), 1'b0, 1'b0, 1'b0);
      tick("postflush");
      chk("pf_pc0", 64'(pc_0), 64'h2000);

      // Count 1 and empty corner cases.
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick("to1");
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick("deq1only");
      chk("deq1_occ", 64'(occupancy), 64'd1);
      drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
      tick("c1pop2");
      chk("c1_occ", 64'(occupancy), 64'd0);
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick("emptypop");
      chk("empty_occ", 64'(occupancy), 64'd0);

      // Asynchronous reset mid-stream.
      drive(1'b1, mk(32'h3000, 1'b0, 1'b1), 1'b0, 1'b0, 1'b0);
      tick("pre_rst");
      tick("pre_rst");
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      sb.delete();
      chk("arst_v0",  64'(valid_0),   64'd0);
      chk("arst_occ", 64'(occupancy), 64'd0);
      chk_status("arst");
      #2;
      rst_n = 1'b1;
      tick("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
